// File: rtl/apb2axi_pkg.sv
// Shared types and AXI encodings for the APB-to-AXI bridge.
package apb2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERR     = 3'd1,
    ST_WR_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_RESP = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle carrying all five channels; the bridge uses the Master view.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

endinterface

// File: rtl/apb2axi_bridge.sv
// APB3 slave that turns each transfer into one single-beat AXI4 master transaction,
// holding the APB wait-state until the AXI response returns.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for an APB access phase
// ST_ERR     | misaligned address: pready+pslverr, no AXI traffic
// ST_WR_REQ  | AW and W offered, each dropped after its handshake
// ST_WR_RESP | b_ready high, waiting for the write response
// ST_RD_REQ  | AR offered until accepted
// ST_RD_RESP | r_ready high, waiting for read data
// ST_DONE    | pready for one cycle with the captured error
module apb2axi_bridge
  import apb2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID        = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_BASE = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  AXI_BUS.Master                    axi_master
);

  state_e                    state;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic                      aw_done;
  logic                      w_done;
  logic                      err_q;

  logic                      aw_valid;
  logic                      w_valid;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      lane;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;

  assign lane     = addr_q[2];
  assign axi_addr = AXI_ADDR_BASE | AXI_ADDR_WIDTH'(addr_q);
  assign aw_valid = (state == ST_WR_REQ) && !aw_done;
  assign w_valid  = (state == ST_WR_REQ) && !w_done;
  assign aw_hs    = aw_valid && axi_master.aw_ready;
  assign w_hs     = w_valid && axi_master.w_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
            if (paddr[1:0] != 2'b00) state <= ST_ERR;
            else if (pwrite)         state <= ST_WR_REQ;
            else                     state <= ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // AW and W may complete in either order or together
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (axi_master.b_valid) begin
            err_q <= resp_is_err(axi_master.b_resp);
            state <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (axi_master.ar_ready) state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (axi_master.r_valid) begin
            prdata <= lane ? axi_master.r_data[63:32] : axi_master.r_data[31:0];
            err_q  <= resp_is_err(axi_master.r_resp);
            state  <= ST_DONE;
          end
        end
        ST_ERR, ST_DONE: state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

  assign pready  = (state == ST_DONE) || (state == ST_ERR);
  assign pslverr = (state == ST_ERR) || ((state == ST_DONE) && err_q);

  assign axi_master.aw_id     = AXI_ID;
  assign axi_master.aw_addr   = axi_addr;
  assign axi_master.aw_len    = 8'd0;
  assign axi_master.aw_size   = AXI_SIZE_4B;
  assign axi_master.aw_burst  = AXI_BURST_INCR;
  assign axi_master.aw_lock   = 1'b0;
  assign axi_master.aw_cache  = 4'd0;
  assign axi_master.aw_prot   = 3'd0;
  assign axi_master.aw_qos    = 4'd0;
  assign axi_master.aw_region = 4'd0;
  assign axi_master.aw_user   = '0;
  assign axi_master.aw_valid  = aw_valid;

  assign axi_master.w_data  = lane ? {wdata_q, 32'h0} : {32'h0, wdata_q};
  assign axi_master.w_strb  = lane ? 8'hF0 : 8'h0F;
  assign axi_master.w_last  = 1'b1;
  assign axi_master.w_user  = '0;
  assign axi_master.w_valid = w_valid;

  assign axi_master.b_ready = (state == ST_WR_RESP);

  assign axi_master.ar_id     = AXI_ID;
  assign axi_master.ar_addr   = axi_addr;
  assign axi_master.ar_len    = 8'd0;
  assign axi_master.ar_size   = AXI_SIZE_4B;
  assign axi_master.ar_burst  = AXI_BURST_INCR;
  assign axi_master.ar_lock   = 1'b0;
  assign axi_master.ar_cache  = 4'd0;
  assign axi_master.ar_prot   = 3'd0;
  assign axi_master.ar_qos    = 4'd0;
  assign axi_master.ar_region = 4'd0;
  assign axi_master.ar_user   = '0;
  assign axi_master.ar_valid  = (state == ST_RD_REQ);

  assign axi_master.r_ready = (state == ST_RD_RESP);

  // Single-beat transfers with a fixed ID: response IDs, user bits and r_last carry no information
  logic unused_ok;
  assign unused_ok = ^{axi_master.b_id, axi_master.b_user, axi_master.r_id,
                       axi_master.r_last, axi_master.r_user};

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Randomized and directed bench for apb2axi_bridge with a transaction-level
// reference model checked every cycle.
module tb_apb2axi_bridge;

  localparam logic [5:0]  TB_ID   = 6'd5;
  localparam logic [31:0] TB_BASE = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) axi ();

  apb2axi_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6),
    .APB_ADDR_WIDTH(32), .AXI_ID(TB_ID), .AXI_ADDR_BASE(TB_BASE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .axi_master(axi)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // slave knobs and shared flags
  bit          rnd_mode = 0;
  bit          hold_b = 0;
  int          w_delay = 0;
  logic [1:0]  next_resp = 2'b00;
  logic [63:0] next_rdata = '0;
  bit          slv_aw = 0, slv_w = 0, slv_ar = 0, b_hs = 0, r_hs = 0, slv_rst = 1;
  int          w_vcnt = 0;
  bit          mon_en = 0;

  // reference model state
  bit          m_act = 0;
  bit          m_wr = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_prdata = '0;
  bit          m_err = 0;
  int          acc_c = 0, aw_c = -1, w_c = -1, ar_c = -1, resp_c = -1;

  // observations for directed checks
  int          n_awv = 0, n_wv = 0, n_aw_hs = 0, n_w_hs = 0, n_any = 0, n_rdy = 0;
  int          last_rdy_c = 0, last_acc_c = 0;
  bit          last_err = 0;
  logic [31:0] last_aw_addr = '0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_wstrb = '0;

  // AXI slave: drives responses one step after the rising edge
  always @(posedge clk_i) begin
    #1;
    axi.b_id = '0; axi.b_user = '0; axi.r_id = '0; axi.r_user = '0; axi.r_last = 1'b1;
    if (slv_rst) begin
      slv_rst = 0;
      axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
      axi.b_valid = 0; axi.r_valid = 0; axi.b_resp = 0; axi.r_resp = 0; axi.r_data = '0;
    end else begin
      axi.aw_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.ar_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.w_ready  = (w_vcnt >= w_delay) && (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      if (b_hs) begin
        axi.b_valid = 0; b_hs = 0;
      end else if (!axi.b_valid && slv_aw && slv_w && !hold_b &&
                   (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        axi.b_valid = 1;
        axi.b_resp  = rnd_mode ? 2'($urandom_range(0, 3)) : next_resp;
        slv_aw = 0; slv_w = 0;
      end
      if (r_hs) begin
        axi.r_valid = 0; r_hs = 0;
      end else if (!axi.r_valid && slv_ar && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        axi.r_valid = 1;
        axi.r_resp  = rnd_mode ? 2'($urandom_range(0, 3)) : next_resp;
        axi.r_data  = rnd_mode ? {$urandom, $urandom} : next_rdata;
        slv_ar = 0;
      end
    end
  end

  // monitor + reference model, evaluated mid-cycle
  always @(negedge clk_i) begin : mon
    logic e_aw, e_w, e_ar, e_b, e_r, e_rdy, e_err;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    int c;
    c = cyc;
    if (rst_i) begin
      slv_aw = 0; slv_w = 0; slv_ar = 0; b_hs = 0; r_hs = 0; w_vcnt = 0; slv_rst = 1;
    end
    if (mon_en) begin
      e_aw = 0; e_w = 0; e_ar = 0; e_b = 0; e_r = 0; e_rdy = 0; e_err = 0;
      if (m_act) begin
        if (m_addr[1:0] != 2'b00) begin
          e_rdy = (c == acc_c + 1);
          e_err = e_rdy;
        end else if (m_wr) begin
          e_aw  = (aw_c < 0);
          e_w   = (w_c < 0);
          e_b   = (aw_c >= 0) && (w_c >= 0) && (resp_c < 0);
          e_rdy = (resp_c >= 0) && (c == resp_c + 1);
          e_err = e_rdy && m_err;
        end else begin
          e_ar  = (ar_c < 0);
          e_r   = (ar_c >= 0) && (resp_c < 0);
          e_rdy = (resp_c >= 0) && (c == resp_c + 1);
          e_err = e_rdy && m_err;
        end
      end
      chk("ctrl{awv,wv,arv,brdy,rrdy,pready,pslverr}",
          {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, pready, pslverr},
          {e_aw, e_w, e_ar, e_b, e_r, e_rdy, e_err});
      chk("prdata", prdata, m_prdata);

      e_wdata = 64'(m_wdata) << (m_addr[2] ? 32 : 0);
      e_wstrb = 8'h0F << (m_addr[2] ? 4 : 0);
      if (axi.aw_valid)
        chk("aw_fields", {axi.aw_addr, axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock,
                          axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_user},
            {TB_BASE | m_addr, TB_ID, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0});
      if (axi.w_valid)
        chk("w_fields", {axi.w_data, axi.w_strb, axi.w_last, axi.w_user}, {e_wdata, e_wstrb, 1'b1, 6'd0});
      if (axi.ar_valid)
        chk("ar_fields", {axi.ar_addr, axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock,
                          axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user},
            {TB_BASE | m_addr, TB_ID, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0});

      if (axi.aw_valid) n_awv++;
      if (axi.w_valid)  n_wv++;
      if (axi.aw_valid || axi.w_valid || axi.ar_valid) n_any++;
      if (pready) begin n_rdy++; last_rdy_c = c; last_err = pslverr; end

      if (rst_i) begin
        m_act = 0; m_prdata = '0;
      end else if (m_act && e_rdy) begin
        m_act = 0;
      end else if (m_act) begin
        if (axi.aw_valid && axi.aw_ready) begin
          aw_c = c; slv_aw = 1; n_aw_hs++; last_aw_addr = axi.aw_addr;
        end
        if (axi.w_valid && axi.w_ready) begin
          w_c = c; slv_w = 1; n_w_hs++; last_wdata = axi.w_data; last_wstrb = axi.w_strb;
        end
        if (axi.ar_valid && axi.ar_ready) begin
          ar_c = c; slv_ar = 1;
        end
        if (axi.b_valid && axi.b_ready) begin
          resp_c = c; m_err = axi.b_resp[1]; b_hs = 1;
        end
        if (axi.r_valid && axi.r_ready) begin
          resp_c = c; m_err = axi.r_resp[1]; r_hs = 1;
          m_prdata = 32'(axi.r_data >> (m_addr[2] ? 32 : 0));
        end
      end else if (psel && penable) begin
        m_act = 1; m_wr = pwrite; m_addr = paddr; m_wdata = pwdata; m_err = 0;
        acc_c = c; last_acc_c = c; aw_c = -1; w_c = -1; ar_c = -1; resp_c = -1;
      end
    end
    if (!rst_i) begin
      if (axi.w_valid && axi.w_ready) w_vcnt = 0;
      else if (axi.w_valid)           w_vcnt++;
    end
  end

  task automatic clr_obs();
    n_awv = 0; n_wv = 0; n_aw_hs = 0; n_w_hs = 0; n_any = 0; n_rdy = 0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 0;
    @(posedge clk_i); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk_i); #1;
    penable = 1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_i);
      if (pready) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL pready_timeout: got no pready want pready within 300 cycles (addr %h)", a);
    end
    @(posedge clk_i); #1;
    psel = 0; penable = 0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic        wr;
    logic [31:0] a;
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_pready_pslverr_prdata", {pready, pslverr, prdata}, 34'd0);
    chk("reset_axi_handshake_outs",
        {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 5'd0);
    mon_en = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    repeat (2) @(posedge clk_i);

    // lane-1 write, AXI always ready
    clr_obs();
    apb_xfer(1, 32'h104, 32'hDEADBEEF);
    settle();
    chk("wr_aw_addr", last_aw_addr, 32'h104);
    chk("wr_w_data", last_wdata, 64'hDEADBEEF_00000000);
    chk("wr_w_strb", last_wstrb, 8'hF0);
    chk("wr_latency", last_rdy_c - last_acc_c, 3);
    chk("wr_pslverr", last_err, 0);

    // lane-0 read
    clr_obs();
    next_rdata = 64'h11112222_33334444;
    apb_xfer(0, 32'h200, 0);
    settle();
    chk("rd_prdata", prdata, 32'h33334444);
    chk("rd_pready_cycles", n_rdy, 1);
    chk("rd_pslverr", last_err, 0);
    chk("rd_latency", last_rdy_c - last_acc_c, 3);

    // W accepted late, AW immediately
    clr_obs();
    w_delay = 5;
    apb_xfer(1, 32'h008, 32'h0BADF00D);
    settle();
    w_delay = 0;
    chk("wdly_aw_valid_cycles", n_awv, 1);
    chk("wdly_w_valid_cycles", n_wv, 6);
    chk("wdly_aw_hs", n_aw_hs, 1);
    chk("wdly_w_hs", n_w_hs, 1);

    // error responses
    next_resp = 2'b11;
    apb_xfer(0, 32'h300, 0);
    chk("rd_decerr_pslverr", last_err, 1);
    next_resp = 2'b10;
    apb_xfer(1, 32'h30C, 32'h1234);
    chk("wr_slverr_pslverr", last_err, 1);
    next_resp = 2'b01;
    apb_xfer(0, 32'h304, 0);
    chk("rd_exokay_pslverr", last_err, 0);
    next_resp = 2'b00;

    // misaligned
    clr_obs();
    apb_xfer(1, 32'h102, 32'h55);
    settle();
    chk("misalign_latency", last_rdy_c - last_acc_c, 1);
    chk("misalign_pslverr", last_err, 1);
    chk("misalign_axi_valids", n_any, 0);
    chk("misalign_pready_cycles", n_rdy, 1);

    // reset while waiting for B
    hold_b = 1;
    @(posedge clk_i); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h40; pwdata = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    penable = 1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_i);
      if (axi.b_ready) got = 1;
    end
    chk("rst_reached_wr_resp", got, 1);
    @(posedge clk_i); #1;
    rst_i = 1; psel = 0; penable = 0;
    @(posedge clk_i); #1;
    rst_i = 0; hold_b = 0;
    @(negedge clk_i);
    chk("rst_mid_outs", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, pready},
        6'd0);
    next_rdata = 64'hCAFEF00D_12345678;
    apb_xfer(0, 32'h10C, 0);
    chk("post_rst_prdata", prdata, 32'hCAFEF00D);
    chk("post_rst_pslverr", last_err, 0);

    // randomized traffic with randomized handshakes and responses
    rnd_mode = 1;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      apb_xfer(wr, a, $urandom);
    end
    rnd_mode = 0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb2axi_bridge.md
Name: apb2axi_bridge

Overview:
- Reverse of the SoC AXI-to-APB path: a single APB3 slave port that turns each APB transfer into exactly one single-beat AXI4 master transaction.
- Lets APB-side masters (debug/config units) reach AXI memory and peripherals.
- Accepts one transfer at a time: APB wait-states (pready low) are held until the AXI response returns.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width; fixed at 64 (two 32-bit lanes).
- AXI_ID_WIDTH, 6, AXI ID width.
- AXI_USER_WIDTH, 6, AXI user width.
- APB_ADDR_WIDTH, 32, APB paddr width; must be <= AXI_ADDR_WIDTH.
- AXI_ID, 0, constant ID driven on aw_id/ar_id.
- AXI_ADDR_BASE, 0, OR-ed onto the zero-extended paddr to form the AXI address.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- paddr  in  APB_ADDR_WIDTH  APB address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB transfer complete.
- pslverr  out  1  APB error.
- axi_master  AXI_BUS.Master  -  AXI4 master port (all channels).

Behaviour:
- Reset values (register state only, so they hold from the first edge with rst_i high):
  - pready=0, pslverr=0, prdata=0.
  - aw_valid=w_valid=ar_valid=0, b_ready=r_ready=0.
  - State = IDLE.
  - Reset mid-transaction abandons it; no AXI valid may remain high.
- FSM states: IDLE, ERR, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - On psel&penable, latch paddr, pwdata and pwrite.
  - If paddr[1:0]!=0, go to ERR.
  - Otherwise go to WR_REQ if pwrite, else RD_REQ.
  - Setup phase (psel & !penable) is ignored.
- ERR: pready=1 and pslverr=1 for one cycle, then IDLE. No AXI activity.
- WR_REQ:
  - aw_valid and w_valid both asserted from the first cycle.
  - Each channel is dropped independently after its own handshake (tracked by aw_done/w_done flags).
  - Go to WR_RESP when both are done; handshakes may occur in the same cycle or in either order.
- WR_RESP:
  - b_ready=1.
  - On b_valid, capture err = b_resp[1] and go to DONE.
- RD_REQ: ar_valid=1 until ar_ready, then go to RD_RESP.
- RD_RESP:
  - r_ready=1.
  - On r_valid, capture the lane-selected r_data into prdata and err = r_resp[1], then go to DONE.
  - r_last is ignored (single beat).
- DONE: pready=1 and pslverr=err for exactly one cycle, then IDLE.
- pready is 0 in all other states.
- prdata holds its value until the next read completes.
- AXI field rules:
  - len=0, size=3'b010 (4 bytes), burst=INCR.
  - lock/cache/prot/qos/region/user = 0.
  - id = AXI_ID.
  - addr = AXI_ADDR_BASE | zero-extended latched paddr.
  - w_last=1.
- Lane rules (lane = paddr[2]):
  - lane 0: w_data = {32'b0, pwdata}, w_strb = 8'h0F.
  - lane 1: w_data = {pwdata, 32'b0}, w_strb = 8'hF0.
  - prdata = r_data[lane*32 +: 32].
- Response codes: OKAY and EXOKAY give no error; SLVERR and DECERR set pslverr.
- Latency with zero-wait AXI: access phase seen in cycle 0 gives pready in cycle 3 (AW/W or AR in cycle 1, B/R in cycle 2).
- A new transfer cannot start while pready=1, because IDLE is re-entered only after DONE/ERR.
- AXI valids never drop before their handshake, and address/data stay stable while valid.

Decomposition:
- Package apb2axi_pkg holds:
  - the state enum;
  - constants AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01;
  - AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- No sub-module; the lane mux is a few lines inside the bridge.

Test Plan:
- Write paddr=0x104, pwdata=0xDEADBEEF, AXI always ready:
  - aw_addr=0x104, w_data=0xDEADBEEF_00000000, w_strb=0xF0.
  - pready high exactly in cycle 3, pslverr=0.
- Read paddr=0x200, r_data=0x11112222_33334444, r_resp=OKAY: prdata=0x33334444, pready one cycle, pslverr=0.
- Write with w_ready delayed 5 cycles and aw_ready immediate:
  - aw_valid drops after 1 cycle; w_valid held 6 cycles.
  - Exactly one AW and one W handshake.
- Read with r_resp=DECERR: pslverr=1 together with pready. Write with b_resp=SLVERR: pslverr=1.
- paddr=0x102: pready=pslverr=1 one cycle after the access phase; zero AXI valids asserted.
- rst_i asserted in WR_RESP: all valids/readies 0 and pready=0 next cycle. A subsequent read completes normally.
